// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register of the 5-stage MIPS32 core with load-use hazard
// detection, bubble insertion, flush/hold control and a saturating bubble counter.
module id_ex_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               ex_hold,
    input  logic [DATA_W-1:0]  id_pc,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_ext32,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic [3:0]         id_alu_op,
    input  logic               id_alu_src,
    input  logic               id_reg_dst,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_mem_to_reg,
    output logic [DATA_W-1:0]  ex_pc,
    output logic [DATA_W-1:0]  ex_rs_data,
    output logic [DATA_W-1:0]  ex_rt_data,
    output logic [DATA_W-1:0]  ex_ext32,
    output logic [RADDR_W-1:0] ex_rs,
    output logic [RADDR_W-1:0] ex_rt,
    output logic [RADDR_W-1:0] ex_rd,
    output logic [3:0]         ex_alu_op,
    output logic               ex_alu_src,
    output logic               ex_reg_dst,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic [RADDR_W-1:0] ex_dest,
    output logic               ex_valid,
    output logic               id_stall,
    output logic [CNT_W-1:0]   bubble_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0]  pc;
        logic [DATA_W-1:0]  rs_data;
        logic [DATA_W-1:0]  rt_data;
        logic [DATA_W-1:0]  ext32;
        logic [RADDR_W-1:0] rs;
        logic [RADDR_W-1:0] rt;
        logic [RADDR_W-1:0] rd;
        logic [3:0]         alu_op;
        logic               alu_src;
        logic               reg_dst;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic [RADDR_W-1:0] dest;
        logic               valid;
    } ex_slot_t;

    ex_slot_t          ex_r;
    ex_slot_t          id_slot_s;
    logic              load_use_s;
    logic [CNT_W-1:0]  bubble_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    function automatic logic reads_reg(input logic uses,
                                       input logic [RADDR_W-1:0] r,
                                       input logic [RADDR_W-1:0] dest);
        return uses && (r == dest);
    endfunction

    // Assemble the slot that would enter EX from the ID-stage inputs.
    always_comb begin
        id_slot_s            = '0;
        id_slot_s.pc         = id_pc;
        id_slot_s.rs_data    = id_rs_data;
        id_slot_s.rt_data    = id_rt_data;
        id_slot_s.ext32      = id_ext32;
        id_slot_s.rs         = id_rs;
        id_slot_s.rt         = id_rt;
        id_slot_s.rd         = id_rd;
        id_slot_s.alu_op     = id_alu_op;
        id_slot_s.alu_src    = id_alu_src;
        id_slot_s.reg_dst    = id_reg_dst;
        id_slot_s.reg_write  = id_reg_write;
        id_slot_s.mem_read   = id_mem_read;
        id_slot_s.mem_write  = id_mem_write;
        id_slot_s.mem_to_reg = id_mem_to_reg;
        id_slot_s.dest       = id_reg_dst ? id_rd : id_rt;
        id_slot_s.valid      = 1'b1;
    end

    // Load-use hazard: a valid load in EX writes a nonzero register the ID instruction reads.
    always_comb begin
        load_use_s = 1'b0;
        if (ex_r.valid && ex_r.mem_read && ex_r.reg_write &&
            (ex_r.dest != {RADDR_W{1'b0}})) begin
            load_use_s = reads_reg(id_uses_rs, id_rs, ex_r.dest) |
                         reads_reg(id_uses_rt, id_rt, ex_r.dest);
        end else begin
            load_use_s = 1'b0;
        end
    end

    assign id_stall = load_use_s | ex_hold;

    // EX slot update; flush and load-use both insert an all-zero bubble (architectural NOP).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_r <= '0;
        end else if (flush) begin
            ex_r <= '0;
        end else if (ex_hold) begin
            ex_r <= ex_r;
        end else if (load_use_s) begin
            ex_r <= '0;
        end else begin
            ex_r <= id_slot_s;
        end
    end

    // Count load-use bubbles only when the load-use rule is the one that fires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else if (!flush && !ex_hold && load_use_s) begin
            bubble_cnt_r <= sat_inc(bubble_cnt_r);
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign ex_pc         = ex_r.pc;
    assign ex_rs_data    = ex_r.rs_data;
    assign ex_rt_data    = ex_r.rt_data;
    assign ex_ext32      = ex_r.ext32;
    assign ex_rs         = ex_r.rs;
    assign ex_rt         = ex_r.rt;
    assign ex_rd         = ex_r.rd;
    assign ex_alu_op     = ex_r.alu_op;
    assign ex_alu_src    = ex_r.alu_src;
    assign ex_reg_dst    = ex_r.reg_dst;
    assign ex_reg_write  = ex_r.reg_write;
    assign ex_mem_read   = ex_r.mem_read;
    assign ex_mem_write  = ex_r.mem_write;
    assign ex_mem_to_reg = ex_r.mem_to_reg;
    assign ex_dest       = ex_r.dest;
    assign ex_valid      = ex_r.valid;
    assign bubble_cnt    = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed scenarios plus random traffic checked
// against a slot-level reference model of the ID/EX register.
module tb_id_ex_stage_reg;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, flush, ex_hold;
    logic [DW-1:0] id_pc, id_rs_data, id_rt_data, id_ext32;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic          id_uses_rs, id_uses_rt;
    logic [3:0]    id_alu_op;
    logic          id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic [DW-1:0] ex_pc, ex_rs_data, ex_rt_data, ex_ext32;
    logic [RW-1:0] ex_rs, ex_rt, ex_rd, ex_dest;
    logic [3:0]    ex_alu_op;
    logic          ex_alu_src, ex_reg_dst, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic          ex_valid, id_stall;
    logic [CW-1:0] bubble_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage_reg #(.DATA_W(DW), .RADDR_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .ex_hold(ex_hold),
        .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_ext32(id_ext32),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg),
        .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_ext32(ex_ext32),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_dest(ex_dest), .ex_valid(ex_valid),
        .id_stall(id_stall), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: what instruction occupies EX, and how many bubbles were inserted.
    typedef struct {
        logic [DW-1:0] pc, rs_data, rt_data, ext32;
        logic [RW-1:0] rs, rt, rd, dest;
        logic [3:0]    alu_op;
        logic          alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, valid;
    } slot_t;

    slot_t m;
    int    m_cnt;

    function automatic slot_t empty_slot();
        slot_t s;
        s = '{pc: 32'd0, rs_data: 32'd0, rt_data: 32'd0, ext32: 32'd0,
              rs: 5'd0, rt: 5'd0, rd: 5'd0, dest: 5'd0, alu_op: 4'd0,
              alu_src: 1'b0, reg_dst: 1'b0, reg_write: 1'b0, mem_read: 1'b0,
              mem_write: 1'b0, mem_to_reg: 1'b0, valid: 1'b0};
        return s;
    endfunction

    function automatic logic model_load_use();
        int loaded;
        if (!(m.valid && m.mem_read && m.reg_write)) return 1'b0;
        loaded = int'(m.dest);
        if (loaded == 0) return 1'b0;
        return (id_uses_rs && int'(id_rs) == loaded) || (id_uses_rt && int'(id_rt) == loaded);
    endfunction

    task automatic model_edge();
        logic lu;
        lu = model_load_use();
        if (flush) begin
            m = empty_slot();
        end else if (ex_hold) begin
            m = m;
        end else if (lu) begin
            m = empty_slot();
            m_cnt = (m_cnt + 1 > 15) ? 15 : m_cnt + 1;
        end else begin
            m.pc = id_pc; m.rs_data = id_rs_data; m.rt_data = id_rt_data; m.ext32 = id_ext32;
            m.rs = id_rs; m.rt = id_rt; m.rd = id_rd; m.alu_op = id_alu_op;
            m.alu_src = id_alu_src; m.reg_dst = id_reg_dst; m.reg_write = id_reg_write;
            m.mem_read = id_mem_read; m.mem_write = id_mem_write; m.mem_to_reg = id_mem_to_reg;
            m.dest = id_reg_dst ? id_rd : id_rt;
            m.valid = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_pc"}, ex_pc, m.pc);
        chk({tag, "_rs_data"}, ex_rs_data, m.rs_data);
        chk({tag, "_rt_data"}, ex_rt_data, m.rt_data);
        chk({tag, "_ext32"}, ex_ext32, m.ext32);
        chk({tag, "_rs"}, 32'(ex_rs), 32'(m.rs));
        chk({tag, "_rt"}, 32'(ex_rt), 32'(m.rt));
        chk({tag, "_rd"}, 32'(ex_rd), 32'(m.rd));
        chk({tag, "_alu_op"}, 32'(ex_alu_op), 32'(m.alu_op));
        chk({tag, "_ctrl"}, {26'd0, ex_alu_src, ex_reg_dst, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
            {26'd0, m.alu_src, m.reg_dst, m.reg_write, m.mem_read, m.mem_write, m.mem_to_reg});
        chk({tag, "_dest"}, 32'(ex_dest), 32'(m.dest));
        chk({tag, "_valid"}, 32'(ex_valid), 32'(m.valid));
        chk({tag, "_cnt"}, 32'(bubble_cnt), m_cnt);
    endtask

    // Called just after a falling edge with ID inputs already set up.
    task automatic step(input string tag);
        #1;
        chk({tag, "_stall"}, 32'(id_stall), 32'(model_load_use() | ex_hold));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic set_nop();
        flush = 1'b0; ex_hold = 1'b0;
        id_pc = 32'd0; id_rs_data = 32'd0; id_rt_data = 32'd0; id_ext32 = 32'd0;
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_alu_op = 4'd0; id_alu_src = 1'b0; id_reg_dst = 1'b0; id_reg_write = 1'b0;
        id_mem_read = 1'b0; id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rt, input logic [31:0] pc);
        set_nop();
        id_pc = pc; id_rs = 5'd29; id_uses_rs = 1'b1; id_rt = rt; id_ext32 = 32'h0000_0010;
        id_alu_src = 1'b1; id_reg_write = 1'b1; id_mem_read = 1'b1; id_mem_to_reg = 1'b1;
    endtask

    task automatic set_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] pc);
        set_nop();
        id_pc = pc; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
        id_rs_data = 32'h1111_0000 ^ pc; id_rt_data = 32'h0000_2222 ^ pc;
        id_alu_op = 4'h2; id_reg_dst = 1'b1; id_reg_write = 1'b1;
    endtask

    initial begin
        m = empty_slot();
        m_cnt = 0;
        set_nop();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outputs("reset");
        chk("reset_stall", 32'(id_stall), 32'd0);

        // T2 passthrough of a sign-extended immediate with rt as destination
        set_nop();
        id_pc = 32'h0040_0004; id_ext32 = 32'hFFFF_8000; id_alu_src = 1'b1;
        id_reg_dst = 1'b0; id_rt = 5'd9; id_rd = 5'd17; id_reg_write = 1'b1;
        step("t2");
        chk("t2_ext32", ex_ext32, 32'hFFFF_8000);
        chk("t2_dest", 32'(ex_dest), 32'd9);
        chk("t2_valid", 32'(ex_valid), 32'd1);

        // T3 lw $8 followed by an add that reads $8: one bubble, then the add enters EX
        set_load(5'd8, 32'h0040_0010);
        step("t3_lw");
        set_add(5'd8, 5'd3, 5'd10, 32'h0040_0014);
        #1;
        chk("t3_stall_hi", 32'(id_stall), 32'd1);
        step("t3_bubble");
        chk("t3_bubble_valid", 32'(ex_valid), 32'd0);
        chk("t3_bubble_regwr", 32'(ex_reg_write), 32'd0);
        chk("t3_cnt", 32'(bubble_cnt), 32'd1);
        #1;
        chk("t3_stall_lo", 32'(id_stall), 32'd0);
        step("t3_add");
        chk("t3_add_dest", 32'(ex_dest), 32'd10);

        // T4 a load to $0 never stalls; a matching rt that is not read never stalls
        set_load(5'd0, 32'h0040_0020);
        step("t4_lw0");
        set_add(5'd0, 5'd0, 5'd4, 32'h0040_0024);
        #1;
        chk("t4_zero_stall", 32'(id_stall), 32'd0);
        step("t4_add0");
        set_load(5'd7, 32'h0040_0028);
        step("t4_lw7");
        set_add(5'd2, 5'd7, 5'd4, 32'h0040_002C);
        id_uses_rt = 1'b0;
        #1;
        chk("t4_unused_rt_stall", 32'(id_stall), 32'd0);
        step("t4_nouse");

        // T5 flush beats hold and load-use; the counter is left alone
        set_load(5'd8, 32'h0040_0030);
        step("t5_lw");
        set_add(5'd8, 5'd8, 5'd5, 32'h0040_0034);
        flush = 1'b1; ex_hold = 1'b1;
        step("t5_prio");
        chk("t5_prio_valid", 32'(ex_valid), 32'd0);
        chk("t5_prio_cnt", 32'(bubble_cnt), 32'd1);
        set_add(5'd1, 5'd2, 5'd6, 32'h0040_0038);
        step("t5_fill");
        for (int i = 0; i < 3; i++) begin
            set_add(5'(i + 11), 5'd12, 5'd13, 32'h0050_0000 + 32'(i));
            ex_hold = 1'b1;
            step("t5_hold");
            chk("t5_hold_pc", ex_pc, 32'h0040_0038);
            chk("t5_hold_dest", 32'(ex_dest), 32'd6);
        end

        // T6 seventeen load-use bubbles saturate the 4-bit counter
        for (int i = 0; i < 17; i++) begin
            set_load(5'd8, 32'h0060_0000 + 32'(i));
            step("t6_lw");
            set_add(5'd3, 5'd8, 5'd9, 32'h0060_1000 + 32'(i));
            step("t6_bubble");
        end
        chk("t6_sat", 32'(bubble_cnt), 32'hF);

        // T1 async reset in the middle of a stall clears EX and drops id_stall at once
        set_load(5'd8, 32'h0070_0000);
        step("t1_lw");
        set_add(5'd8, 5'd1, 5'd2, 32'h0070_0004);
        #1;
        chk("t1_pre_stall", 32'(id_stall), 32'd1);
        reset = 1'b1;
        #1;
        m = empty_slot();
        m_cnt = 0;
        check_outputs("t1_reset");
        chk("t1_stall", 32'(id_stall), 32'd0);
        #1;
        reset = 1'b0;
        @(negedge clk);

        // Random traffic on a small register set to provoke hazards often
        for (int i = 0; i < 1500; i++) begin
            id_pc = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_ext32 = $urandom;
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            id_rd = 5'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
            id_alu_op = 4'($urandom); id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom);
            id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
            id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
            flush = ($urandom_range(0, 15) == 0);
            ex_hold = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
